// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} memState_t;

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/half of a raw read word and sign/zero-extends it.
module load_align_ext
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {24'b0, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {16'b0, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: runs one req/ack bus transaction per load/store,
// stalls the pipeline while it is outstanding and aborts on timeout.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk_Mem,
   input  logic        rst_n_Mem,
   input  logic        MemRead_in_Mem,
   input  logic        MemWrite_in_Mem,
   input  logic [2:0]  funct3_in_Mem,
   input  logic [31:0] ALU_in_Mem,
   input  logic [31:0] Store_data_in_Mem,
   output logic        bus_req_out,
   output logic        bus_we_out,
   output logic [31:0] bus_addr_out,
   output logic [31:0] bus_wdata_out,
   output logic [3:0]  bus_wstrb_out,
   input  logic        bus_ack_in,
   input  logic [31:0] bus_rdata_in,
   output logic [31:0] DMem_data_out_Mem,
   output logic        stall_out_Mem,
   output logic        misalign_out_Mem,
   output logic        bus_err_out_Mem
);

   memState_t        state, nextState;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3Reg;
   logic [1:0]       offReg;
   logic             op, misaligned, accept, timeout;
   logic [3:0]       strbNext;
   logic [31:0]      wdataNext, loadData;

   assign op      = MemRead_in_Mem | MemWrite_in_Mem;
   assign accept  = op & ~misaligned;
   // Expires on the TIMEOUT_CYCLES-th BUSY cycle; an ack in that cycle still wins.
   assign timeout = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      case (funct3_in_Mem[1:0])
         2'b01:   misaligned = ALU_in_Mem[0];
         2'b10:   misaligned = (ALU_in_Mem[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      strbNext  = 4'b0000;
      wdataNext = Store_data_in_Mem;
      if (MemWrite_in_Mem) begin
         case (funct3_in_Mem[1:0])
            2'b00: begin
               strbNext  = 4'b0001 << ALU_in_Mem[1:0];
               wdataNext = {4{Store_data_in_Mem[7:0]}};
            end
            2'b01: begin
               strbNext  = 4'b0011 << ALU_in_Mem[1:0];
               wdataNext = {2{Store_data_in_Mem[15:0]}};
            end
            default: strbNext = 4'b1111;
         endcase
      end
   end

   load_align_ext uAlign (
      .rdata  (bus_rdata_in),
      .offset (offReg),
      .funct3 (f3Reg),
      .result (loadData)
   );

   always_ff @(posedge clk_Mem or negedge rst_n_Mem) begin
      if (!rst_n_Mem) state <= S_IDLE;
      else            state <= nextState;
   end

   always_comb begin
      nextState     = state;
      stall_out_Mem = 1'b0;
      case (state)
         S_IDLE: if (accept) begin
            nextState     = S_BUSY;
            stall_out_Mem = 1'b1;
         end
         S_BUSY: begin
            stall_out_Mem = 1'b1;
            if (bus_ack_in || timeout) nextState = S_DONE;
         end
         S_DONE:  nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
      // Stall must read low while reset is held, even with an op presented.
      if (!rst_n_Mem) stall_out_Mem = 1'b0;
   end

   always_ff @(posedge clk_Mem or negedge rst_n_Mem) begin
      if (!rst_n_Mem) begin
         cnt               <= '0;
         f3Reg             <= '0;
         offReg            <= '0;
         bus_req_out       <= 1'b0;
         bus_we_out        <= 1'b0;
         bus_addr_out      <= '0;
         bus_wdata_out     <= '0;
         bus_wstrb_out     <= '0;
         DMem_data_out_Mem <= '0;
         misalign_out_Mem  <= 1'b0;
         bus_err_out_Mem   <= 1'b0;
      end else begin
         misalign_out_Mem <= 1'b0;
         bus_err_out_Mem  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (op && misaligned) begin
                  misalign_out_Mem  <= 1'b1;
                  DMem_data_out_Mem <= '0;
               end else if (op) begin
                  bus_req_out   <= 1'b1;
                  bus_we_out    <= MemWrite_in_Mem;
                  bus_addr_out  <= {ALU_in_Mem[31:2], 2'b00};
                  bus_wdata_out <= wdataNext;
                  bus_wstrb_out <= strbNext;
                  f3Reg         <= funct3_in_Mem;
                  offReg        <= ALU_in_Mem[1:0];
               end
            end
            S_BUSY: begin
               if (bus_ack_in) begin
                  bus_req_out       <= 1'b0;
                  DMem_data_out_Mem <= bus_we_out ? 32'b0 : loadData;
               end else if (timeout) begin
                  bus_req_out       <= 1'b0;
                  DMem_data_out_Mem <= '0;
                  bus_err_out_Mem   <= 1'b1;
               end
               if (cnt != '1) cnt <= cnt + 1'b1;
            end
            S_DONE:  cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (built with a 4-cycle timeout).
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk_Mem = 1'b0;
   logic        rst_n_Mem;
   logic        MemRead_in_Mem, MemWrite_in_Mem;
   logic [2:0]  funct3_in_Mem;
   logic [31:0] ALU_in_Mem, Store_data_in_Mem;
   logic        bus_req_out, bus_we_out;
   logic [31:0] bus_addr_out, bus_wdata_out;
   logic [3:0]  bus_wstrb_out;
   logic        bus_ack_in;
   logic [31:0] bus_rdata_in;
   logic [31:0] DMem_data_out_Mem;
   logic        stall_out_Mem, misalign_out_Mem, bus_err_out_Mem;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [31:0] addr, wdata, data;
      logic [3:0]  strb;
      logic        we, err;
      int          stalls;
   } exp_t;
   exp_t expQ[$];

   mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk_Mem(clk_Mem), .rst_n_Mem(rst_n_Mem),
      .MemRead_in_Mem(MemRead_in_Mem), .MemWrite_in_Mem(MemWrite_in_Mem),
      .funct3_in_Mem(funct3_in_Mem), .ALU_in_Mem(ALU_in_Mem),
      .Store_data_in_Mem(Store_data_in_Mem),
      .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
      .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out),
      .bus_wstrb_out(bus_wstrb_out), .bus_ack_in(bus_ack_in),
      .bus_rdata_in(bus_rdata_in), .DMem_data_out_Mem(DMem_data_out_Mem),
      .stall_out_Mem(stall_out_Mem), .misalign_out_Mem(misalign_out_Mem),
      .bus_err_out_Mem(bus_err_out_Mem)
   );

   always #5 clk_Mem = ~clk_Mem;

   function automatic exp_t mkExp(logic [31:0] a, logic [31:0] wd, logic [3:0] st,
                                  logic we, logic [31:0] d, logic er, int sc);
      exp_t e;
      e.addr = a; e.wdata = wd; e.strb = st; e.we = we; e.data = d; e.err = er; e.stalls = sc;
      return e;
   endfunction

   // Reference load: pick bytes by explicit lane index, then extend.
   function automatic logic [31:0] refLoad(logic [31:0] w, logic [1:0] o, logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*o +: 8];
      h = o[1] ? w[31:16] : w[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // Drives one access, acks on BUSY cycle ackAt (0 = never), checks against the queue head.
   task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int ackAt);
      exp_t e;
      int   busy, stalls;
      bit   done;
      e = expQ.pop_front();
      @(negedge clk_Mem);
      MemRead_in_Mem = rd; MemWrite_in_Mem = wr; funct3_in_Mem = f3;
      ALU_in_Mem = a; Store_data_in_Mem = sd; bus_ack_in = 1'b0; bus_rdata_in = rdata;
      #1;
      stalls = stall_out_Mem ? 1 : 0;
      busy = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk_Mem);
         if (bus_req_out) begin
            busy++;
            if (busy == 1) begin
               vecs++;
               if (bus_addr_out !== e.addr || bus_wstrb_out !== e.strb || bus_we_out !== e.we) begin
                  errs++;
                  $display("FAIL busfields addr=%h strb=%b we=%b required addr=%h strb=%b we=%b",
                           bus_addr_out, bus_wstrb_out, bus_we_out, e.addr, e.strb, e.we);
               end
               if (e.we) begin
                  vecs++;
                  if (bus_wdata_out !== e.wdata) begin
                     errs++;
                     $display("FAIL wdata got=%h required=%h", bus_wdata_out, e.wdata);
                  end
               end
            end
            bus_ack_in = (busy == ackAt);
            #1;
            if (stall_out_Mem) stalls++;
         end else begin
            bus_ack_in = 1'b0;
            MemRead_in_Mem = 1'b0; MemWrite_in_Mem = 1'b0;
            #1;
            vecs++;
            if (DMem_data_out_Mem !== e.data || bus_err_out_Mem !== e.err ||
                stall_out_Mem !== 1'b0 || stalls != e.stalls) begin
               errs++;
               $display("FAIL done data=%h err=%b stall=%b stalls=%0d required data=%h err=%b stall=0 stalls=%0d",
                        DMem_data_out_Mem, bus_err_out_Mem, stall_out_Mem, stalls,
                        e.data, e.err, e.stalls);
            end
            done = 1'b1;
         end
      end
      if (!done) begin
         vecs++; errs++;
         $display("FAIL access_timeout got=no_completion required=completion");
         bus_ack_in = 1'b0; MemRead_in_Mem = 1'b0; MemWrite_in_Mem = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n_Mem = 1'b0; bus_ack_in = 1'b0; bus_rdata_in = '0;
      MemRead_in_Mem = 1'b1; MemWrite_in_Mem = 1'b0; funct3_in_Mem = F3_W;
      ALU_in_Mem = 32'h100; Store_data_in_Mem = '0;
      #12;
      vecs++;
      if (stall_out_Mem !== 1'b0 || bus_req_out !== 1'b0 || bus_we_out !== 1'b0 ||
          bus_addr_out !== '0 || bus_wdata_out !== '0 || bus_wstrb_out !== '0 ||
          DMem_data_out_Mem !== '0 || misalign_out_Mem !== 1'b0 || bus_err_out_Mem !== 1'b0) begin
         errs++;
         $display("FAIL reset stall=%b req=%b addr=%h data=%h required all zero",
                  stall_out_Mem, bus_req_out, bus_addr_out, DMem_data_out_Mem);
      end
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b0; rst_n_Mem = 1'b1;
   endtask

   task automatic test_loads();
      expQ.push_back(mkExp(32'h100, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 1);
      expQ.push_back(mkExp(32'h100, 32'h0, 4'b0000, 1'b0, 32'hFFFFFF80, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_B,  32'h103, 32'h0, 32'h80FF1234, 1);
      expQ.push_back(mkExp(32'h100, 32'h0, 4'b0000, 1'b0, 32'h00000080, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, 1);
      expQ.push_back(mkExp(32'h100, 32'h0, 4'b0000, 1'b0, 32'hFFFF80FF, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_H,  32'h102, 32'h0, 32'h80FF1234, 1);
      expQ.push_back(mkExp(32'h100, 32'h0, 4'b0000, 1'b0, 32'h000080FF, 1'b0, 3));
      runAccess(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF1234, 2);
   endtask

   task automatic test_stores();
      expQ.push_back(mkExp(32'h200, 32'hABABABAB, 4'b0010, 1'b1, 32'h0, 1'b0, 4));
      runAccess(1'b0, 1'b1, F3_B, 32'h201, 32'h000000AB, 32'h55555555, 3);
      expQ.push_back(mkExp(32'h200, 32'h56785678, 4'b1100, 1'b1, 32'h0, 1'b0, 2));
      runAccess(1'b0, 1'b1, F3_H, 32'h202, 32'h12345678, 32'h0, 1);
      // Read and write both set: write wins.
      expQ.push_back(mkExp(32'h204, 32'hCAFEBABE, 4'b1111, 1'b1, 32'h0, 1'b0, 2));
      runAccess(1'b1, 1'b1, F3_W, 32'h204, 32'hCAFEBABE, 32'h0, 1);
   endtask

   task automatic test_random_loads();
      logic [2:0]  f3s [5];
      logic [2:0]  f3;
      logic [31:0] a, w;
      int          ak;
      f3s = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
      for (int i = 0; i < 8; i++) begin
         f3 = f3s[$urandom_range(0, 4)];
         a  = {16'h0, 14'($urandom), 2'($urandom)};
         if (f3[1:0] == 2'b01) a[0] = 1'b0;
         if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         w  = $urandom;
         ak = $urandom_range(1, 3);
         expQ.push_back(mkExp({a[31:2], 2'b00}, 32'h0, 4'b0000, 1'b0, refLoad(w, a[1:0], f3), 1'b0, ak + 1));
         runAccess(1'b1, 1'b0, f3, a, 32'h0, w, ak);
      end
   endtask

   task automatic test_misalign();
      expQ.push_back(mkExp(32'h104, 32'h0, 4'b0000, 1'b0, 32'h11223344, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_W, 32'h104, 32'h0, 32'h11223344, 1);
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b1; funct3_in_Mem = F3_W; ALU_in_Mem = 32'h102;
      #1;
      vecs++;
      if (stall_out_Mem !== 1'b0) begin
         errs++; $display("FAIL misalign_stall got=%b required=0", stall_out_Mem);
      end
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b0;
      vecs++;
      if (misalign_out_Mem !== 1'b1 || bus_req_out !== 1'b0 || DMem_data_out_Mem !== 32'h0) begin
         errs++;
         $display("FAIL misalign_pulse mis=%b req=%b data=%h required mis=1 req=0 data=0",
                  misalign_out_Mem, bus_req_out, DMem_data_out_Mem);
      end
      @(negedge clk_Mem);
      vecs++;
      if (misalign_out_Mem !== 1'b0 || bus_req_out !== 1'b0) begin
         errs++;
         $display("FAIL misalign_clear mis=%b req=%b required 0 0", misalign_out_Mem, bus_req_out);
      end
      // Halfword at odd address is also rejected.
      expQ.push_back(mkExp(32'h108, 32'h0, 4'b0000, 1'b0, 32'h00005566, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_HU, 32'h108, 32'h0, 32'h77885566, 1);
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b1; funct3_in_Mem = F3_H; ALU_in_Mem = 32'h10B;
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b0;
      vecs++;
      if (misalign_out_Mem !== 1'b1 || bus_req_out !== 1'b0 || DMem_data_out_Mem !== 32'h0) begin
         errs++;
         $display("FAIL misalign_half mis=%b req=%b data=%h required 1 0 0",
                  misalign_out_Mem, bus_req_out, DMem_data_out_Mem);
      end
   endtask

   task automatic test_timeout();
      expQ.push_back(mkExp(32'h300, 32'h0, 4'b0000, 1'b0, 32'hCAFEF00D, 1'b0, 3));
      runAccess(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'hCAFEF00D, 2);
      expQ.push_back(mkExp(32'h300, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 5));
      runAccess(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'h99999999, 0);
      @(negedge clk_Mem);
      vecs++;
      if (bus_err_out_Mem !== 1'b0 || stall_out_Mem !== 1'b0 || bus_req_out !== 1'b0) begin
         errs++;
         $display("FAIL timeout_after err=%b stall=%b req=%b required 0 0 0",
                  bus_err_out_Mem, stall_out_Mem, bus_req_out);
      end
      expQ.push_back(mkExp(32'h304, 32'h0, 4'b0000, 1'b0, 32'h0BADF00D, 1'b0, 5));
      runAccess(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 32'h0BADF00D, 4);
   endtask

   task automatic test_reset_busy();
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b1; funct3_in_Mem = F3_W; ALU_in_Mem = 32'h400;
      @(negedge clk_Mem);
      vecs++;
      if (bus_req_out !== 1'b1) begin
         errs++; $display("FAIL rstbusy_req got=%b required=1", bus_req_out);
      end
      rst_n_Mem = 1'b0;
      #1;
      vecs++;
      if (bus_req_out !== 1'b0 || stall_out_Mem !== 1'b0) begin
         errs++;
         $display("FAIL rstbusy_drop req=%b stall=%b required 0 0", bus_req_out, stall_out_Mem);
      end
      @(negedge clk_Mem);
      MemRead_in_Mem = 1'b0; rst_n_Mem = 1'b1;
      @(negedge clk_Mem);
      bus_ack_in = 1'b1; bus_rdata_in = 32'h12345678;
      @(negedge clk_Mem);
      bus_ack_in = 1'b0;
      #1;
      vecs++;
      if (bus_req_out !== 1'b0 || stall_out_Mem !== 1'b0 || DMem_data_out_Mem !== 32'h0) begin
         errs++;
         $display("FAIL late_ack req=%b stall=%b data=%h required 0 0 0",
                  bus_req_out, stall_out_Mem, DMem_data_out_Mem);
      end
      expQ.push_back(mkExp(32'h400, 32'h0, 4'b0000, 1'b0, 32'hA5A5C3C3, 1'b0, 2));
      runAccess(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 32'hA5A5C3C3, 1);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_random_loads();
      test_misalign();
      test_timeout();
      test_reset_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
